// File: rtl/fulladder_nb_triple.sv
// fulladder_nb_triple: three independent full-adder lanes plus a clocked lane-agreement monitor
module fulladder_nb_triple #(
  parameter int MISM_CNT_W = 8,
  parameter bit FAULT_V = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_sv,
  input  logic b_sv,
  input  logic cin_sv,
  output logic s_sv,
  output logic cout_sv,
  input  logic a_v,
  input  logic b_v,
  input  logic cin_v,
  output logic s_v,
  output logic cout_v,
  input  logic a_vhd,
  input  logic b_vhd,
  input  logic cin_vhd,
  output logic s_vhd,
  output logic cout_vhd,
  output logic lane_mismatch,
  output logic [MISM_CNT_W-1:0] mismatch_cnt
);
  logic p_sv, g_sv, p_v, g_v, p_vhd, g_vhd, same, diff;
  assign p_sv = a_sv ^ b_sv;
  assign g_sv = a_sv & b_sv;
  assign s_sv = p_sv ^ cin_sv;
  assign cout_sv = g_sv | (p_sv & cin_sv);
  assign p_v = a_v ^ b_v;
  assign g_v = a_v & b_v;
  // FAULT_V is a stub that corrupts the v-lane sum so the monitor can be exercised
  assign s_v = p_v ^ cin_v ^ FAULT_V;
  assign cout_v = g_v | (p_v & cin_v);
  assign p_vhd = a_vhd ^ b_vhd;
  assign g_vhd = a_vhd & b_vhd;
  assign s_vhd = p_vhd ^ cin_vhd;
  assign cout_vhd = g_vhd | (p_vhd & cin_vhd);
  assign same = ({a_sv, b_sv, cin_sv} == {a_v, b_v, cin_v}) && ({a_sv, b_sv, cin_sv} == {a_vhd, b_vhd, cin_vhd});
  assign diff = same && (({s_sv, cout_sv} != {s_v, cout_v}) || ({s_sv, cout_sv} != {s_vhd, cout_vhd}));
  // sticky flag and saturating counter of edges where equal-input lanes disagree
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lane_mismatch <= 1'b0;
      mismatch_cnt <= '0;
    end else if (diff) begin
      lane_mismatch <= 1'b1;
      mismatch_cnt <= (&mismatch_cnt) ? mismatch_cnt : mismatch_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fulladder_nb_triple.sv
// tb_fulladder_nb_triple: directed checks of adder lanes and the lane-agreement monitor
module tb_fulladder_nb_triple;
  logic clk = 1'b0;
  logic reset_n, rf_n;
  logic a_sv, b_sv, cin_sv, a_v, b_v, cin_v, a_vhd, b_vhd, cin_vhd;
  logic s_sv, cout_sv, s_v, cout_v, s_vhd, cout_vhd, lm0;
  logic s_svf, cout_svf, s_vf, cout_vf, s_vhdf, cout_vhdf, lmf;
  logic [7:0] cnt0, cntf;
  logic [1:0] exp_tab [8];
  int checks = 0;
  int passed = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fulladder_nb_triple #(.MISM_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_sv(a_sv), .b_sv(b_sv), .cin_sv(cin_sv), .s_sv(s_sv), .cout_sv(cout_sv),
    .a_v(a_v), .b_v(b_v), .cin_v(cin_v), .s_v(s_v), .cout_v(cout_v),
    .a_vhd(a_vhd), .b_vhd(b_vhd), .cin_vhd(cin_vhd), .s_vhd(s_vhd), .cout_vhd(cout_vhd),
    .lane_mismatch(lm0), .mismatch_cnt(cnt0)
  );

  fulladder_nb_triple #(.MISM_CNT_W(8), .FAULT_V(1'b1)) dut_f (
    .clk(clk), .reset_n(rf_n),
    .a_sv(a_sv), .b_sv(b_sv), .cin_sv(cin_sv), .s_sv(s_svf), .cout_sv(cout_svf),
    .a_v(a_v), .b_v(b_v), .cin_v(cin_v), .s_v(s_vf), .cout_v(cout_vf),
    .a_vhd(a_vhd), .b_vhd(b_vhd), .cin_vhd(cin_vhd), .s_vhd(s_vhdf), .cout_vhd(cout_vhdf),
    .lane_mismatch(lmf), .mismatch_cnt(cntf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [2:0] vsv, input logic [2:0] vv, input logic [2:0] vvhd);
    {a_sv, b_sv, cin_sv} = vsv;
    {a_v, b_v, cin_v} = vv;
    {a_vhd, b_vhd, cin_vhd} = vvhd;
  endtask

  task automatic check_lanes(input string tag, input logic [1:0] esv, input logic [1:0] ev, input logic [1:0] evhd);
    check({tag, "_sv"}, {30'd0, s_sv, cout_sv}, {30'd0, esv});
    check({tag, "_v"}, {30'd0, s_v, cout_v}, {30'd0, ev});
    check({tag, "_vhd"}, {30'd0, s_vhd, cout_vhd}, {30'd0, evhd});
  endtask

  initial begin
    exp_tab[0] = 2'b00; exp_tab[1] = 2'b10; exp_tab[2] = 2'b10; exp_tab[3] = 2'b01;
    exp_tab[4] = 2'b10; exp_tab[5] = 2'b01; exp_tab[6] = 2'b01; exp_tab[7] = 2'b11;
    reset_n = 1'b1;
    rf_n = 1'b1;
    drive(3'b000, 3'b000, 3'b000);
    #2 reset_n = 1'b0;
    rf_n = 1'b0;
    #1;
    check("rst_lm", {31'd0, lm0}, 32'd0);
    check("rst_cnt", {24'd0, cnt0}, 32'd0);
    check("rst_lmf", {31'd0, lmf}, 32'd0);
    check("rst_cntf", {24'd0, cntf}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(i[2:0], i[2:0], i[2:0]);
      #1 check_lanes("in_reset", exp_tab[i], exp_tab[i], exp_tab[i]);
      #3;
    end
    check("in_reset_cnt", {24'd0, cnt0}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive(i[2:0], i[2:0], i[2:0]);
      @(negedge clk) check_lanes("exh", exp_tab[i], exp_tab[i], exp_tab[i]);
    end
    @(posedge clk);
    #1;
    check("exh_lm", {31'd0, lm0}, 32'd0);
    check("exh_cnt", {24'd0, cnt0}, 32'd0);
    @(posedge clk);
    #1 drive(3'b111, 3'b000, 3'b101);
    @(negedge clk) check_lanes("split", 2'b11, 2'b00, 2'b01);
    rf_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("split_cntf", {24'd0, cntf}, 32'd0);
    check("split_lmf", {31'd0, lmf}, 32'd0);
    drive(3'b110, 3'b110, 3'b110);
    #1 check("lat_cntf_pre", {24'd0, cntf}, 32'd0);
    @(negedge clk) check_lanes("in110", 2'b01, 2'b01, 2'b01);
    check("in110_faulty_s_v", {31'd0, s_vf}, 32'd1);
    check("lat_lmf_pre", {31'd0, lmf}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_cntf_1", {24'd0, cntf}, 32'd1);
    check("lat_lmf_1", {31'd0, lmf}, 32'd1);
    check("lat_lm0", {31'd0, lm0}, 32'd0);
    @(posedge clk);
    #1 check("cntf_2", {24'd0, cntf}, 32'd2);
    #2 rf_n = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_cntf", {24'd0, cntf}, 32'd0);
    check("mid_rst_lmf", {31'd0, lmf}, 32'd0);
    check_lanes("mid_rst_lanes", 2'b01, 2'b01, 2'b01);
    @(negedge clk);
    rf_n = 1'b1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("sat_cnt_10", {24'd0, cntf}, 32'd10);
    repeat (290) @(posedge clk);
    #1;
    check("sat_cnt_255", {24'd0, cntf}, 32'd255);
    check("sat_lmf", {31'd0, lmf}, 32'd1);
    check("sat_lm0", {31'd0, lm0}, 32'd0);
    check("sat_cnt0", {24'd0, cnt0}, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
